// File: rtl/store_monitor_pkg.sv
// Shared types and default sizing for the store monitor: the captured store record
// and the FIFO/drop-counter dimensions used by the top and its storage.
package store_monitor_pkg;

    localparam int STORE_W          = 32;
    localparam int STORE_FIFO_DEPTH = 8;
    localparam int DROP_CNT_W       = 8;
    localparam int STORE_REC_W      = 2 * STORE_W;

    typedef struct packed {
        logic [STORE_W-1:0] addr;
        logic [STORE_W-1:0] data;
    } store_rec_t;

    // Builds a record from a raw store; keeps field ordering in one place.
    function automatic store_rec_t make_rec(input logic [STORE_W-1:0] addr,
                                            input logic [STORE_W-1:0] data);
        store_rec_t rec;
        rec.addr = addr;
        rec.data = data;
        return rec;
    endfunction

endpackage

// File: rtl/store_fifo_mem.sv
// Record storage for the store FIFO: one synchronous write port, one combinational
// read port. Contents are not reset; validity is tracked by the owner's count.
module store_fifo_mem
    import store_monitor_pkg::*;
#(
    parameter int DEPTH = STORE_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   wr_en_i,
    input  logic [AW-1:0]          wr_ptr_i,
    input  logic [STORE_REC_W-1:0] wr_rec_i,
    input  logic [AW-1:0]          rd_ptr_i,
    output logic [STORE_REC_W-1:0] rd_rec_o
);

    store_rec_t mem_q [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (wr_en_i && (wr_ptr_i == AW'(gi))) begin
                    mem_q[gi] <= store_rec_t'(wr_rec_i);
                end
            end
        end
    endgenerate

    assign rd_rec_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/store_monitor.sv
// Watches the CPU data-memory write port: buffers stores in a first-word-fall-through
// FIFO for a downstream drain, counts stores lost to a full FIFO, and flags a watched store.
module store_monitor
    import store_monitor_pkg::*;
#(
    parameter int  n     = STORE_W,
    parameter int  DEPTH = STORE_FIFO_DEPTH,
    parameter int  DW    = DROP_CNT_W,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          memwrite,
    input  logic [n-1:0]  dataadr,
    input  logic [n-1:0]  writedata,
    input  logic [n-1:0]  match_addr,
    input  logic [n-1:0]  match_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [n-1:0]  out_addr,
    output logic [n-1:0]  out_data,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic [DW-1:0] drop_count,
    output logic          match_hit
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [DW-1:0] drop_count_q, drop_count_d;
    logic          match_hit_q, match_hit_d;

    logic full;
    logic valid;
    logic push_raw;
    logic push;
    logic pop;
    logic drop;
    logic store_match;

    logic [STORE_REC_W-1:0] wr_rec;
    logic [STORE_REC_W-1:0] rd_rec_raw;
    store_rec_t             rd_rec;

    assign full     = (count_q == CW'(DEPTH));
    assign valid    = (count_q != '0);
    assign push_raw = en & memwrite;
    assign pop      = valid & out_ready;
    // A full FIFO still accepts a store when the head leaves in the same cycle.
    assign push     = push_raw & (~full | pop);
    assign drop     = push_raw & ~push;
    // Matching ignores FIFO occupancy so a dropped store can still signal completion.
    assign store_match = push_raw & (dataadr == match_addr) & (writedata == match_data);

    assign wr_rec = make_rec(dataadr, writedata);

    store_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk      (clk),
        .wr_en_i  (push & ~reset),
        .wr_ptr_i (wr_ptr_q),
        .wr_rec_i (wr_rec),
        .rd_ptr_i (rd_ptr_q),
        .rd_rec_o (rd_rec_raw)
    );

    assign rd_rec = store_rec_t'(rd_rec_raw);

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        match_hit_d  = match_hit_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + 1'b1;
            end
        end

        if (store_match) begin
            match_hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            match_hit_q  <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            match_hit_q  <= match_hit_d;
        end
    end

    // Stale storage is masked so an empty FIFO always presents zeros.
    assign out_valid  = valid;
    assign out_addr   = valid ? rd_rec.addr : '0;
    assign out_data   = valid ? rd_rec.data : '0;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
    assign match_hit  = match_hit_q;

endmodule
